clock_rate_checker: RTL and testbench

- Receiving end of the divided-clock path: samples a slow clock-like signal (for example a counter-generated divided clock) in the `clk` domain.
- Detects its edges and measures period and high time in `clk` cycles.
- Declares lock when the measured rate matches the expected CLK_FREQ/EXPECTED_FREQ ratio.
- Used as a sanity monitor on generated clocks and as an edge/tick source for downstream logic.

---
 rtl/clock_rate_checker.sv | 193 +++++++++++++++++++
 tb/tb_clock_rate_checker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_rate_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : clock_rate_checker
// Brief  : Synchronizes a slow clock-like input, emits rise/fall pulses,
//          measures period and high time in clk cycles and reports lock
//          when the period matches CLK_FREQ/EXPECTED_FREQ.
// Option : CLOCK_RATE_CHECKER_DUTY_CHECK_EN - when defined, a period only
//          matches if the high time captured since the previous rise is
//          within TOLERANCE of TICKS - TICKS/2.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module clock_rate_checker #(
  parameter int CLK_FREQ      = 12_000_000,
  parameter int EXPECTED_FREQ = 3_000_000,
  parameter int TOLERANCE     = 0,
  parameter int LOCK_COUNT    = 4,
  parameter int SYNC_STAGES   = 2,
  localparam int TICKS        = CLK_FREQ / EXPECTED_FREQ,
  localparam int PBITS        = $clog2(2*TICKS + TOLERANCE + 2)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [PBITS-1:0] period,
  output logic [PBITS-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam int MBITS = $clog2(LOCK_COUNT + 1);

  // Saturation point of the cycle counter; reaching it means the input stalled.
  localparam logic [PBITS-1:0] C_TIMEOUT = PBITS'(2*TICKS + TOLERANCE);
  // Acceptable period window, lower bound never below one cycle.
  localparam logic [PBITS-1:0] C_PER_LO  = PBITS'((TICKS > TOLERANCE) ? (TICKS - TOLERANCE) : 1);
  localparam logic [PBITS-1:0] C_PER_HI  = PBITS'(TICKS + TOLERANCE);
  localparam logic [MBITS-1:0] C_LOCK_N  = MBITS'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   sync_s;

  state_t                 state_q, state_d;
  logic [MBITS-1:0]       mcnt_q, mcnt_d;
  logic [PBITS-1:0]       cnt_q, cnt_d;
  logic [PBITS-1:0]       period_q, period_d;
  logic [PBITS-1:0]       high_q, high_d;
  logic                   pv_q, pv_d;
  logic                   lost_q, lost_d;
  logic                   match_s;

  // Shift chain input: the new sample enters at bit 0.
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      assign sync_d = clk_in;
    end else begin : g_sync_chain
      assign sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
    end
  endgenerate

  assign sync_s     = sync_q[SYNC_STAGES-1];
  assign rise_pulse = sync_s & ~prev_q;
  assign fall_pulse = ~sync_s & prev_q;

  // Synchronizer flops plus the previous-sample register used for edge detect.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_s;
    end
  end

`ifdef CLOCK_RATE_CHECKER_DUTY_CHECK_EN
  localparam int HTGT = TICKS - TICKS/2;
  localparam logic [PBITS-1:0] C_HI_LO = PBITS'((HTGT > TOLERANCE) ? (HTGT - TOLERANCE) : 0);
  localparam logic [PBITS-1:0] C_HI_HI = PBITS'(HTGT + TOLERANCE);

  logic fseen_q, fseen_d;

  // Remembers whether a falling edge has been seen since the last rise.
  always_ff @(posedge clk) begin
    if (!resetn) fseen_q <= 1'b0;
    else         fseen_q <= fseen_d;
  end

  always_comb begin
    fseen_d = fseen_q;
    if (rise_pulse)      fseen_d = 1'b0;
    else if (fall_pulse) fseen_d = 1'b1;
  end

  assign match_s = (cnt_q >= C_PER_LO) && (cnt_q <= C_PER_HI) && fseen_q &&
                   (high_q >= C_HI_LO) && (high_q <= C_HI_HI);
`else
  assign match_s = (cnt_q >= C_PER_LO) && (cnt_q <= C_PER_HI);
`endif

  // State, counters and measurement registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_SEARCH;
      mcnt_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      pv_q     <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      pv_q     <= pv_d;
      lost_q   <= lost_d;
    end
  end

  // Next-state logic: a rise always re-references the counter, so it takes
  // priority over a timeout landing in the same cycle.
  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    cnt_d    = (cnt_q == C_TIMEOUT) ? cnt_q : cnt_q + PBITS'(1);
    period_d = period_q;
    high_d   = high_q;
    pv_d     = 1'b0;
    lost_d   = 1'b0;

    if (fall_pulse) high_d = cnt_q;

    if (rise_pulse) begin
      cnt_d = PBITS'(1);
      if (state_q != S_SEARCH) begin
        period_d = cnt_q;
        pv_d     = 1'b1;
      end
      case (state_q)
        S_SEARCH: begin
          state_d = S_ACQUIRE;
          mcnt_d  = '0;
        end
        S_ACQUIRE: begin
          if (match_s) begin
            if (mcnt_q + MBITS'(1) == C_LOCK_N) begin
              state_d = S_LOCKED;
              mcnt_d  = '0;
            end else begin
              mcnt_d  = mcnt_q + MBITS'(1);
            end
          end else begin
            mcnt_d = '0;
          end
        end
        S_LOCKED: begin
          if (!match_s) begin
            state_d = S_ACQUIRE;
            mcnt_d  = '0;
            lost_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_SEARCH;
          mcnt_d  = '0;
        end
      endcase
    end else if ((state_q != S_SEARCH) && (cnt_q == C_TIMEOUT)) begin
      lost_d  = (state_q == S_LOCKED);
      state_d = S_SEARCH;
      mcnt_d  = '0;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = pv_q;
  assign lost         = lost_q;
  assign locked       = (state_q == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_clock_rate_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_clock_rate_checker
// Brief  : Self-checking bench for clock_rate_checker. Two instances share the
//          stimulus (TOLERANCE 0 and 1); a timestamp-based reference model
//          predicts every output each cycle.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_clock_rate_checker;

  localparam int SYNC  = 2;
  localparam int TICKS = 4;
  localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCK = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clk_in = 1'b0;

  logic       rise0, fall0, pv0, lk0, lost0;
  logic [3:0] per0, ht0;
  logic       rise1, fall1, pv1, lk1, lost1;
  logic [3:0] per1, ht1;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  clock_rate_checker #(.TOLERANCE(0)) u_t0 (
    .clk(clk), .resetn(resetn), .clk_in(clk_in),
    .rise_pulse(rise0), .fall_pulse(fall0), .period(per0), .high_time(ht0),
    .period_valid(pv0), .locked(lk0), .lost(lost0)
  );

  clock_rate_checker #(.TOLERANCE(1)) u_t1 (
    .clk(clk), .resetn(resetn), .clk_in(clk_in),
    .rise_pulse(rise1), .fall_pulse(fall1), .period(per1), .high_time(ht1),
    .period_valid(pv1), .locked(lk1), .lost(lost1)
  );

  wire [12:0] obs0 = {rise0, fall0, per0, ht0, pv0, lk0, lost0};
  wire [12:0] obs1 = {rise1, fall1, per1, ht1, pv1, lk1, lost1};

  // ---------------- reference model ----------------
  // Edges come from a delay line of raw samples; the counter is derived from
  // the timestamp of the last reference event, saturated at the timeout.
  int  m_t = 0;
  bit  m_smp [0:SYNC];
  bit  m_rise = 1'b0, m_fall = 1'b0;
  int  m_tol [2] = '{0, 1};
  int  m_mode[2], m_mc[2], m_per[2], m_ht[2], m_ref[2];
  bit  m_pv[2], m_lost[2], m_fseen[2];
  logic [12:0] exp_v [2];

  always @(posedge clk) begin
    int c, d, tmo;
    bit match;
    m_t++;
    for (int i = 0; i < 2; i++) begin
      tmo = 2*TICKS + m_tol[i];
      if (!resetn) begin
        m_mode[i] = M_SEARCH; m_mc[i] = 0; m_per[i] = 0; m_ht[i] = 0;
        m_pv[i] = 0; m_lost[i] = 0; m_fseen[i] = 0; m_ref[i] = m_t;
      end else begin
        c = (m_t - 1) - m_ref[i];
        if (c > tmo) c = tmo;
        m_pv[i] = 0; m_lost[i] = 0;
        if (m_fall) begin m_ht[i] = c; m_fseen[i] = 1; end
        if (m_rise) begin
          d = c - TICKS; if (d < 0) d = -d;
          match = (d <= m_tol[i]);
`ifdef CLOCK_RATE_CHECKER_DUTY_CHECK_EN
          d = m_ht[i] - (TICKS - TICKS/2); if (d < 0) d = -d;
          match = match && m_fseen[i] && (d <= m_tol[i]);
`endif
          if (m_mode[i] == M_SEARCH) begin
            m_mode[i] = M_ACQ; m_mc[i] = 0;
          end else begin
            m_pv[i] = 1; m_per[i] = c;
            if (m_mode[i] == M_ACQ) begin
              if (match) begin
                m_mc[i]++;
                if (m_mc[i] == 4) begin m_mode[i] = M_LOCK; m_mc[i] = 0; end
              end else m_mc[i] = 0;
            end else if (!match) begin
              m_mode[i] = M_ACQ; m_mc[i] = 0; m_lost[i] = 1;
            end
          end
          m_ref[i] = m_t - 1;
          m_fseen[i] = 0;
        end else if (m_mode[i] != M_SEARCH && c == tmo) begin
          m_lost[i] = (m_mode[i] == M_LOCK);
          m_mode[i] = M_SEARCH; m_mc[i] = 0;
        end
      end
    end
    if (!resetn) begin
      for (int k = 0; k <= SYNC; k++) m_smp[k] = 0;
    end else begin
      for (int k = SYNC; k > 0; k--) m_smp[k] = m_smp[k-1];
      m_smp[0] = clk_in;
    end
    m_rise = m_smp[SYNC-1] & ~m_smp[SYNC];
    m_fall = ~m_smp[SYNC-1] & m_smp[SYNC];
    for (int i = 0; i < 2; i++)
      exp_v[i] = {m_rise, m_fall, 4'(m_per[i]), 4'(m_ht[i]), m_pv[i],
                  m_mode[i] == M_LOCK, m_lost[i]};
  end

  // Drive one cycle of stimulus and move to the sampling point.
  task automatic tick(input bit v);
    clk_in = v;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1'($urandom_range(1, 0)));
      nchk++;
      if ({obs1, obs0} !== 26'h0) begin
        nerr++;
        $display("FAIL reset_zero cyc %0d: got %h required %h", c, {obs1, obs0}, 26'h0);
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_lock_p4();
    for (int c = 0; c < 40; c++) begin
      tick((c % 4) < 2);
      nchk++;
      if ({obs1, obs0} !== {exp_v[1], exp_v[0]}) begin
        nerr++;
        $display("FAIL lock_p4 cyc %0d: got %h required %h", c, {obs1, obs0}, {exp_v[1], exp_v[0]});
      end
    end
    nchk++;
    if ({lk0, per0, ht0} !== {1'b1, 4'd4, 4'd2}) begin
      nerr++;
      $display("FAIL lock_p4_final: got lk/per/ht %h required %h", {lk0, per0, ht0}, {1'b1, 4'd4, 4'd2});
    end
  endtask

  task automatic test_timeout();
    int nlost = 0, npv = 0;
    for (int c = 0; c < 16; c++) begin
      tick(1'b0);
      nlost += int'(lost0) + int'(lost1);
      npv   += int'(pv0) + int'(pv1);
      nchk++;
      if ({obs1, obs0} !== {exp_v[1], exp_v[0]}) begin
        nerr++;
        $display("FAIL timeout cyc %0d: got %h required %h", c, {obs1, obs0}, {exp_v[1], exp_v[0]});
      end
    end
    nchk++;
    if (nlost != 2 || npv != 0 || {lk1, lk0} !== 2'b00) begin
      nerr++;
      $display("FAIL timeout_final: got lost=%0d pv=%0d locked=%b required lost=2 pv=0 locked=00",
               nlost, npv, {lk1, lk0});
    end
  endtask

  task automatic test_period5();
    for (int c = 0; c < 50; c++) begin
      tick((c % 5) < 2);
      nchk++;
      if ({obs1, obs0} !== {exp_v[1], exp_v[0]}) begin
        nerr++;
        $display("FAIL period5 cyc %0d: got %h required %h", c, {obs1, obs0}, {exp_v[1], exp_v[0]});
      end
    end
    nchk++;
    if ({lk0, lk1, per0, per1} !== {1'b0, 1'b1, 4'd5, 4'd5}) begin
      nerr++;
      $display("FAIL period5_final: got %h required %h", {lk0, lk1, per0, per1}, {1'b0, 1'b1, 4'd5, 4'd5});
    end
  endtask

  task automatic test_glitch_period();
    int nlost = 0;
    bit lost_ok = 1'b0;
    for (int c = 0; c < 86; c++) begin
      if (c < 40)      tick((c % 4) < 2);
      else if (c < 46) tick((c - 40) < 2);
      else             tick(((c - 46) % 4) < 2);
      if (c >= 40) begin
        nlost += int'(lost0);
        if (lost0 && pv0 && per0 == 4'd6 && !lk0) lost_ok = 1'b1;
      end
      nchk++;
      if ({obs1, obs0} !== {exp_v[1], exp_v[0]}) begin
        nerr++;
        $display("FAIL glitch cyc %0d: got %h required %h", c, {obs1, obs0}, {exp_v[1], exp_v[0]});
      end
    end
    nchk++;
    if (nlost != 1 || !lost_ok || lk0 !== 1'b1) begin
      nerr++;
      $display("FAIL glitch_final: got lost=%0d coincident=%b locked=%b required 1 1 1", nlost, lost_ok, lk0);
    end
  endtask

  task automatic test_reset_mid();
    int extra = $urandom_range(3, 1);
    for (int c = 0; c < 40 + extra; c++) tick((c % 4) < 2);
    resetn = 1'b0;
    tick(((40 + extra) % 4) < 2);
    nchk++;
    if ({obs1, obs0} !== 26'h0) begin
      nerr++;
      $display("FAIL reset_mid: got %h required %h", {obs1, obs0}, 26'h0);
    end
    resetn = 1'b1;
    for (int c = 0; c < 44; c++) begin
      tick((c % 4) < 2);
      nchk++;
      if ({obs1, obs0} !== {exp_v[1], exp_v[0]}) begin
        nerr++;
        $display("FAIL reset_mid_reacq cyc %0d: got %h required %h", c, {obs1, obs0}, {exp_v[1], exp_v[0]});
      end
    end
    nchk++;
    if (lk0 !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid_relock: got %b required 1", lk0);
    end
  endtask

  task automatic test_duty();
    bit exp_lk;
`ifdef CLOCK_RATE_CHECKER_DUTY_CHECK_EN
    exp_lk = 1'b0;
`else
    exp_lk = 1'b1;
`endif
    for (int c = 0; c < 40; c++) begin
      tick((c % 4) < 3);
      nchk++;
      if ({obs1, obs0} !== {exp_v[1], exp_v[0]}) begin
        nerr++;
        $display("FAIL duty cyc %0d: got %h required %h", c, {obs1, obs0}, {exp_v[1], exp_v[0]});
      end
    end
    nchk++;
    if ({lk0, ht0} !== {exp_lk, 4'd3}) begin
      nerr++;
      $display("FAIL duty_final: got lk/ht %h required %h", {lk0, ht0}, {exp_lk, 4'd3});
    end
  endtask

  task automatic test_random();
    int per, hi, reps;
    for (int s = 0; s < 40; s++) begin
      per  = $urandom_range(10, 2);
      hi   = $urandom_range(per - 1, 1);
      reps = $urandom_range(4, 1);
      for (int r = 0; r < reps; r++) begin
        for (int c = 0; c < per; c++) begin
          resetn = ($urandom_range(63, 0) != 0);
          tick(c < hi);
          nchk++;
          if ({obs1, obs0} !== {exp_v[1], exp_v[0]}) begin
            nerr++;
            $display("FAIL random seg %0d: got %h required %h", s, {obs1, obs0}, {exp_v[1], exp_v[0]});
          end
        end
      end
    end
    resetn = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_lock_p4();
    test_timeout();
    test_period5();
    test_glitch_period();
    test_reset_mid();
    test_duty();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
